lsu_unit: RTL and testbench

//  Load/store unit directly downstream of the ALU in the EX stage. It takes alu_result as
//  the effective address, issues one aligned 64-bit memory request, and aligns and extends

---
 rtl/lsu_unit.sv | 175 +++++++++++++++++
 tb/tb_lsu_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit sitting behind the EX-stage ALU. It takes alu_result as the effective
// address, issues one aligned 64-bit memory request per load/store, and aligns and
// sign/zero-extends load data. Non-memory ops and misaligned accesses complete in one
// cycle without touching memory. Exactly one op is in flight at a time.
module lsu_unit #(
    parameter int XLEN   = 64,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_mem_op,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_rf_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_rf_wen,
    output logic              out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic              is_load_q;

    logic              mem_req_valid_q;
    logic [XLEN-1:0]   mem_req_addr_q;
    logic              mem_req_wen_q;
    logic [XLEN-1:0]   mem_req_wdata_q;
    logic [7:0]        mem_req_wmask_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_data_q;
    logic [RIDX_W-1:0] out_rd_q;
    logic              out_rf_wen_q;
    logic              out_misalign_q;

    logic              accept;
    logic              is_mem;
    logic              misalign_d;
    logic [7:0]        wmask_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   rdata_shift;
    logic [XLEN-1:0]   load_data_d;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = in_is_load | in_is_store;
    assign wdata_d  = in_wdata << {in_addr[2:0], 3'b000};

    // Alignment check and byte-lane mask for the incoming op's access size.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // can leave it unassigned and infer a latch.
        misalign_d = 1'b0;
        wmask_d    = 8'h00;
        case (in_mem_op[1:0])
            2'd0: begin misalign_d = 1'b0;            wmask_d = 8'h01; end
            2'd1: begin misalign_d = in_addr[0];      wmask_d = 8'h03; end
            2'd2: begin misalign_d = |in_addr[1:0];   wmask_d = 8'h0F; end
            default: begin misalign_d = |in_addr[2:0]; wmask_d = 8'hFF; end
        endcase
        wmask_d = wmask_d << in_addr[2:0];
    end

    // Shift the addressed bytes of the response down to bit 0 and extend to XLEN.
    always_comb begin
        rdata_shift = mem_resp_rdata >> {addr_q[2:0], 3'b000};
        load_data_d = rdata_shift;
        case (size_q)
            2'd0: load_data_d = {{(XLEN-8){~zext_q & rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1: load_data_d = {{(XLEN-16){~zext_q & rdata_shift[15]}}, rdata_shift[15:0]};
            2'd2: load_data_d = {{(XLEN-32){~zext_q & rdata_shift[31]}}, rdata_shift[31:0]};
            default: load_data_d = rdata_shift;
        endcase
    end

    // Control FSM with all outputs registered; reset clears every output field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            size_q          <= '0;
            zext_q          <= 1'b0;
            is_load_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wen_q   <= 1'b0;
            mem_req_wdata_q <= '0;
            mem_req_wmask_q <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_rd_q        <= '0;
            out_rf_wen_q    <= 1'b0;
            out_misalign_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q         <= in_addr;
                        size_q         <= in_mem_op[1:0];
                        zext_q         <= in_mem_op[2];
                        is_load_q      <= in_is_load & ~in_is_store;
                        out_rd_q       <= in_rd;
                        out_misalign_q <= is_mem & misalign_d;
                        out_rf_wen_q   <= in_rf_wen & ~(is_mem & misalign_d);
                        if (!is_mem || misalign_d) begin
                            out_data_q  <= in_addr;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {in_addr[XLEN-1:3], 3'b000};
                            mem_req_wen_q   <= in_is_store;
                            mem_req_wmask_q <= in_is_store ? wmask_d : 8'h00;
                            mem_req_wdata_q <= wdata_d;
                            state_q         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        out_data_q  <= is_load_q ? load_data_d : addr_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wen   = mem_req_wen_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_wmask = mem_req_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_rd        = out_rd_q;
    assign out_rf_wen    = out_rf_wen_q;
    assign out_misalign  = out_misalign_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: the stimulus process computes expected memory requests
// and results from the access rules, a memory responder and a writeback monitor check
// what the DUT presents against those queues.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_mem_op;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic        resp_valid_r;
    logic        stray_resp;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_rf_wen;
    logic        out_misalign;

    assign mem_resp_valid = resp_valid_r | stray_resp;

    lsu_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_mem_op(in_mem_op),
        .in_rd(in_rd), .in_rf_wen(in_rf_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_rf_wen(out_rf_wen), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          stall;
        int          delay;
        bit          no_resp;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rf_wen;
        logic        misalign;
        int          issue_cyc;
        int          lat;
        int          ostall;
    } out_t;

    req_t req_q[$];
    out_t out_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Expected load result: gather the addressed bytes, then extend arithmetically.
    function automatic logic [63:0] load_ref(input logic [63:0] rdata, input int off,
                                             input int nb, input bit zext);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++)
            v = v | (64'(rdata[8*(off+i) +: 8]) << (8*i));
        if (!zext && nb < 8 && v[8*nb-1])
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
        return v;
    endfunction

    // Memory responder: checks each request against the scoreboard and replies.
    initial begin
        req_t e;
        mem_req_ready  = 1'b0;
        resp_valid_r   = 1'b0;
        mem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid) begin
                if (req_q.size() == 0) begin
                    check("unexpected_mem_req", {63'd0, mem_req_valid}, 64'd0);
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                end else begin
                    e = req_q.pop_front();
                    for (int s = 0; s <= e.stall; s++) begin
                        if (s > 0) @(negedge clk);
                        check("req_valid", {63'd0, mem_req_valid}, 64'd1);
                        check("req_addr", mem_req_addr, e.addr);
                        check("req_wen", {63'd0, mem_req_wen}, {63'd0, e.wen});
                        check("req_wmask", {56'd0, mem_req_wmask}, {56'd0, e.wmask});
                        if (e.wen) check("req_wdata", mem_req_wdata, e.wdata);
                        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
                    end
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    check("req_valid_drop", {63'd0, mem_req_valid}, 64'd0);
                    if (!e.no_resp) begin
                        repeat (e.delay) @(negedge clk);
                        resp_valid_r   = 1'b1;
                        mem_resp_rdata = e.rdata;
                        @(negedge clk);
                        resp_valid_r   = 1'b0;
                        mem_resp_rdata = {$urandom, $urandom};
                    end
                end
            end
        end
    end

    // Writeback monitor: pops the expected result whenever out_valid is presented.
    initial begin
        out_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (out_q.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = out_q.pop_front();
                    check("latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
                    for (int s = 0; s <= e.ostall; s++) begin
                        if (s > 0) @(negedge clk);
                        check("out_valid", {63'd0, out_valid}, 64'd1);
                        check("out_data", out_data, e.data);
                        check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                        check("out_rf_wen", {63'd0, out_rf_wen}, {63'd0, e.rf_wen});
                        check("out_misalign", {63'd0, out_misalign}, {63'd0, e.misalign});
                        check("in_ready_done", {63'd0, in_ready}, 64'd0);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("out_valid_drop", {63'd0, out_valid}, 64'd0);
                check("in_ready_after", {63'd0, in_ready}, 64'd1);
            end
        end
    end

    // Issue one op: compute its expected request/result, then present it for one cycle.
    task automatic issue(input logic [63:0] addr, input logic [63:0] wdata, input bit ld,
                         input bit st, input logic [2:0] op, input logic [4:0] rd,
                         input bit rf_wen, input logic [63:0] rdata, input int rqs,
                         input int rsd, input int ost, input bit no_resp);
        int   t;
        int   nb;
        int   off;
        bit   is_mem;
        bit   mis;
        req_t r;
        out_t o;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            timeout("wait_in_ready");
            return;
        end
        nb     = 1 << op[1:0];
        off    = int'(addr % 8);
        is_mem = ld || st;
        mis    = is_mem && ((addr % 64'(nb)) != 0);
        o.rd        = rd;
        o.misalign  = mis;
        o.rf_wen    = rf_wen && !mis;
        o.issue_cyc = cyc;
        o.ostall    = ost;
        if (!is_mem || mis) begin
            o.data = addr;
            o.lat  = 1;
        end else begin
            r.addr  = addr - 64'(off);
            r.wen   = st;
            r.wmask = '0;
            if (st)
                for (int i = 0; i < nb; i++) r.wmask[off+i] = 1'b1;
            r.wdata   = wdata << (8*off);
            r.rdata   = rdata;
            r.stall   = rqs;
            r.delay   = rsd;
            r.no_resp = no_resp;
            req_q.push_back(r);
            o.data = st ? addr : load_ref(rdata, off, nb, op[2]);
            o.lat  = 3 + rqs + rsd;
        end
        if (!no_resp) out_q.push_back(o);
        in_valid    = 1'b1;
        in_addr     = addr;
        in_wdata    = wdata;
        in_is_load  = ld;
        in_is_store = st;
        in_mem_op   = op;
        in_rd       = rd;
        in_rf_wen   = rf_wen;
        @(negedge clk);
        in_valid    = 1'b0;
        in_addr     = {$urandom, $urandom};
        in_wdata    = {$urandom, $urandom};
        in_is_load  = $urandom_range(0, 1) == 1;
        in_is_store = 1'b0;
        in_mem_op   = 3'($urandom_range(0, 7));
    endtask

    // Check that every DUT output sits at its reset value.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
        check({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
        check({tag, "_mem_req_wen"}, {63'd0, mem_req_wen}, 64'd0);
        check({tag, "_mem_req_wdata"}, mem_req_wdata, 64'd0);
        check({tag, "_mem_req_wmask"}, {56'd0, mem_req_wmask}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_out_rd"}, {59'd0, out_rd}, 64'd0);
        check({tag, "_out_rf_wen"}, {63'd0, out_rf_wen}, 64'd0);
        check({tag, "_out_misalign"}, {63'd0, out_misalign}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int t;
        rst_n       = 1'b0;
        stray_resp  = 1'b0;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_mem_op   = '0;
        in_rd       = '0;
        in_rf_wen   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed cases
        issue(64'h1234, 64'h0, 0, 0, 3'd3, 5'd7, 1, 64'h0, 0, 0, 0, 0);
        issue(64'h1003, 64'h0, 1, 0, 3'd0, 5'd1, 1, 64'h0000_0000_8000_0000, 0, 0, 0, 0);
        issue(64'h1003, 64'h0, 1, 0, 3'd4, 5'd2, 1, 64'h0000_0000_8000_0000, 0, 0, 0, 0);
        issue(64'h2006, 64'hBEEF, 0, 1, 3'd1, 5'd3, 1, 64'h0, 0, 0, 0, 0);
        issue(64'h2006, 64'hBEEF, 0, 1, 3'd1, 5'd4, 0, 64'h0, 0, 0, 0, 0);
        issue(64'h2002, 64'h0, 1, 0, 3'd2, 5'd5, 1, 64'h0, 0, 0, 0, 0);
        issue(64'h4008, 64'h0, 1, 0, 3'd3, 5'd6, 1, 64'h0123_4567_89AB_CDEF, 3, 0, 2, 0);
        issue(64'h4004, 64'h1122_3344_8899_AABB, 0, 1, 3'd2, 5'd8, 1, 64'h0, 3, 1, 2, 0);
        issue(64'h400C, 64'h0, 1, 0, 3'd6, 5'd9, 1, 64'h8000_0001_0000_0000, 0, 0, 0, 0);

        // Reset while waiting for the memory response; a late response must be ignored.
        issue(64'h3000, 64'h0, 1, 0, 3'd3, 5'd10, 1, 64'h55, 0, 0, 0, 1);
        t = 0;
        while (!mem_req_valid && t < 20) begin @(negedge clk); t++; end
        while (mem_req_valid && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) timeout("reach_wait");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        @(negedge clk);
        rst_n      = 1'b1;
        stray_resp = 1'b1;
        @(negedge clk);
        stray_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_out_valid", {63'd0, out_valid}, 64'd0);
            check("stray_in_ready", {63'd0, in_ready}, 64'd1);
            check("stray_out_data", out_data, 64'd0);
        end

        // Randomized ops
        for (int n = 0; n < 150; n++) begin
            int          k;
            logic [2:0]  op;
            logic [63:0] a;
            k  = $urandom_range(0, 2);
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << op[1:0]) - 64'd1);
            issue(a, {$urandom, $urandom}, k == 1, k == 2, op, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 0);
        end

        t = 0;
        while ((out_q.size() != 0 || req_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("out_queue_drained", 64'(out_q.size()), 64'd0);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
